// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
//
// Wall-clock time keeper with an hour:min:sec counter, a four-mode setting
// state machine (RUN, SET_HOUR, SET_MIN, SET_SEC) and an optional alarm
// comparator.
//
// Optional feature macro: TIME_COUNTER_ALARM_EN
//   defined   -> alarm comparator compiled in, alarm_hit pulses on match
//   undefined -> alarm inputs ignored, alarm_hit is constant 0
//
// Parameters
//   TICKS_PER_SEC  clk cycles per second (>= 2)
//   HOUR_MOD       hour modulus, hours count 0..HOUR_MOD-1 (<= 64)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   mode_btn    one-cycle pulse, advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
//   inc_btn     one-cycle pulse, increments the selected field in SET modes
//   alarm_on    alarm enable
//   alarm_hour  alarm hour compare value
//   alarm_min   alarm minute compare value
//   sec/min/hour  registered binary time
//   sel_field   current mode (0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC)
//   sec_tick    one-cycle pulse with each counted second
//   day_wrap    one-cycle pulse when counting rolls over to 00:00:00
//   alarm_hit   one-cycle pulse, coincident with the matching time value
// ---------------------------------------------------------------------------
module time_counter #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int HOUR_MOD      = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       alarm_on,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hour,
    output logic [1:0] sel_field,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       alarm_hit
);

    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    HOUR_LAST  = 6'(HOUR_MOD - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hour_q, hour_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_wrap_q, day_wrap_d;
    logic          alarm_hit_q, alarm_hit_d;
    logic          count_en;

    // A second is counted only while running and the prescaler is terminal.
    // This is evaluated on the current state, so a mode_btn arriving in the
    // same cycle still lets the final increment land.
    assign count_en = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;

        if (mode_btn) begin
            case (state_q)
                ST_RUN:      state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_SEC;
                default:     state_d = ST_RUN;
            endcase
        end

        if (state_q == ST_RUN) begin
            if (count_en) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        if (hour_q == HOUR_LAST) begin
                            hour_d     = 6'd0;
                            day_wrap_d = 1'b1;
                        end else begin
                            hour_d = hour_q + 6'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
            // Leaving RUN: park the prescaler so the next RUN entry starts
            // a full second from zero.
            if (mode_btn) begin
                presc_d = '0;
            end
        end else begin
            presc_d = '0;
            // mode_btn has priority over inc_btn; fields wrap independently.
            if (inc_btn && !mode_btn) begin
                case (state_q)
                    ST_SET_HOUR: hour_d = (hour_q == HOUR_LAST) ? 6'd0 : hour_q + 6'd1;
                    ST_SET_MIN:  min_d  = (min_q  == 6'd59)     ? 6'd0 : min_q  + 6'd1;
                    default:     sec_d  = (sec_q  == 6'd59)     ? 6'd0 : sec_q  + 6'd1;
                endcase
            end
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    logic alarm_in_range;
    // Out-of-range compare values are rejected explicitly so they can never
    // alias onto a reachable time.
    assign alarm_in_range = ({1'b0, alarm_hour} < 7'(HOUR_MOD)) && (alarm_min <= 6'd59);
    // Compare against the next time so the pulse lines up with the new value.
    assign alarm_hit_d = count_en && alarm_on && alarm_in_range &&
                         (sec_d == 6'd0) && (min_d == alarm_min) && (hour_d == alarm_hour);
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_on, alarm_hour, alarm_min};
    assign alarm_hit_d  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 6'd0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_tick_q  <= sec_tick_d;
            day_wrap_q  <= day_wrap_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign sel_field = state_q;
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_time_counter.sv
// ---------------------------------------------------------------------------
// tb_time_counter
//
// Self-checking bench for time_counter with TICKS_PER_SEC=4, HOUR_MOD=24.
// A vector table of SET-mode / RUN-entry steps is pushed through a
// scoreboard queue; hand-written sequences cover counting, day wrap,
// field wrap, reset priority, terminal-count corner cases and the alarm.
// Alarm expectations follow TIME_COUNTER_ALARM_EN.
// ---------------------------------------------------------------------------
module tb_time_counter;

    localparam int TPS = 4;
    localparam int HM  = 24;
`ifdef TIME_COUNTER_ALARM_EN
    localparam int ALARM_BUILT = 1;
`else
    localparam int ALARM_BUILT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_btn;
    logic       inc_btn;
    logic       alarm_on;
    logic [5:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hour;
    logic [1:0] sel_field;
    logic       sec_tick;
    logic       day_wrap;
    logic       alarm_hit;

    time_counter #(
        .TICKS_PER_SEC (TPS),
        .HOUR_MOD      (HM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .alarm_on   (alarm_on),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .sel_field  (sel_field),
        .sec_tick   (sec_tick),
        .day_wrap   (day_wrap),
        .alarm_hit  (alarm_hit)
    );

    always #5 clk = ~clk;

    int total_checks  = 0;
    int passed_checks = 0;

    typedef struct {
        logic       mode;
        logic       inc;
        logic [1:0] sel;
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       tick;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       tick;
        logic       wrap;
        logic       hit;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int req);
        total_checks++;
        if (act == req) passed_checks++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        cycle();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_state(input string tag, input int s_sel, input int h, input int m, input int s);
        check($sformatf("%s.sel", tag),  int'(sel_field), s_sel);
        check($sformatf("%s.hour", tag), int'(hour), h);
        check($sformatf("%s.min", tag),  int'(min), m);
        check($sformatf("%s.sec", tag),  int'(sec), s);
    endtask

    task automatic check_pulses(input string tag, input int t, input int w, input int a);
        check($sformatf("%s.sec_tick", tag),  int'(sec_tick), t);
        check($sformatf("%s.day_wrap", tag),  int'(day_wrap), w);
        check($sformatf("%s.alarm_hit", tag), int'(alarm_hit), a);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("%s.sb_empty", tag), 1, 0);
        end else begin
            e = sb.pop_front();
            check_state(tag, int'(e.sel), int'(e.h), int'(e.m), int'(e.s));
            check_pulses(tag, int'(e.tick), int'(e.wrap), int'(e.hit));
        end
    endtask

    // From RUN right after reset: walk the SET modes and load h:m:s.
    // Ends in SET_SEC.
    task automatic set_time(input int h, input int m, input int s);
        pulse(1'b1, 1'b0);
        repeat (h) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (m) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (s) pulse(1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        exp_t e;
        int   ticks;
        int   bad;
        int   hits;
        int   hit_cycle;

        rst_n      = 1'b0;
        mode_btn   = 1'b0;
        inc_btn    = 1'b0;
        alarm_on   = 1'b0;
        alarm_hour = 6'd0;
        alarm_min  = 6'd2;

        //            mode  inc   sel   hour  min   sec   tick
        vecs[0]  = '{1'b1, 1'b0, 2'd1, 6'd0, 6'd0, 6'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 6'd1, 6'd0, 6'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 6'd2, 6'd0, 6'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd2, 6'd2, 6'd0, 6'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 6'd2, 6'd1, 6'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 6'd2, 6'd1, 6'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 6'd2, 6'd1, 6'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 6'd2, 6'd1, 6'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 6'd2, 6'd1, 6'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 6'd2, 6'd1, 6'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 6'd2, 6'd1, 6'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 6'd2, 6'd1, 6'd2, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 6'd2, 6'd1, 6'd3, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 6'd2, 6'd1, 6'd3, 1'b0};

        // Reset state
        do_reset();
        check_state("reset", 0, 0, 0, 0);
        check_pulses("reset", 0, 0, 0);

        // Vector table through the scoreboard
        for (int i = 0; i < 14; i++) begin
            e.sel  = vecs[i].sel;
            e.h    = vecs[i].h;
            e.m    = vecs[i].m;
            e.s    = vecs[i].s;
            e.tick = vecs[i].tick;
            e.wrap = 1'b0;
            e.hit  = 1'b0;
            sb.push_back(e);
            mode_btn = vecs[i].mode;
            inc_btn  = vecs[i].inc;
            cycle();
            mode_btn = 1'b0;
            inc_btn  = 1'b0;
            $display("vec %0d: mode=%0b inc=%0b -> sel=%0d %0d:%0d:%0d tick=%0b",
                     i, vecs[i].mode, vecs[i].inc, sel_field, hour, min, sec, sec_tick);
            pop_compare($sformatf("vec%0d", i));
        end

        // 240 cycles from reset: tick every 4th cycle, 00:01:00 at the end
        do_reset();
        ticks = 0;
        bad   = 0;
        for (int i = 1; i <= 240; i++) begin
            cycle();
            if (int'(sec_tick) != ((i % TPS) == 0 ? 1 : 0)) bad++;
            ticks += int'(sec_tick);
        end
        $display("run240: ticks=%0d time=%0d:%0d:%0d", ticks, hour, min, sec);
        check("run240.tick_spacing_errors", bad, 0);
        check("run240.tick_count", ticks, 60);
        check_state("run240", 0, 0, 1, 0);

        // Day wrap from 23:59:59
        do_reset();
        set_time(23, 59, 59);
        pulse(1'b1, 1'b0);
        check_state("preload", 0, 23, 59, 59);
        ticks = 0;
        repeat (TPS - 1) begin
            cycle();
            ticks += int'(sec_tick) + int'(day_wrap);
        end
        check("daywrap.early_pulses", ticks, 0);
        cycle();
        $display("daywrap: %0d:%0d:%0d tick=%0b wrap=%0b", hour, min, sec, sec_tick, day_wrap);
        check_state("daywrap", 0, 0, 0, 0);
        check_pulses("daywrap", 1, 1, 0);
        cycle();
        check_pulses("daywrap_after", 0, 0, 0);

        // 61 increments in SET_MIN wrap to 1, other fields untouched
        do_reset();
        pulse(1'b1, 1'b0);
        repeat (3) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        ticks = 0;
        for (int i = 0; i < 61; i++) begin
            pulse(1'b0, 1'b1);
            ticks += int'(sec_tick);
        end
        $display("setmin61: sel=%0d %0d:%0d:%0d ticks=%0d", sel_field, hour, min, sec, ticks);
        check_state("setmin61", 2, 3, 1, 0);
        check("setmin61.ticks", ticks, 0);

        // Reset in SET_SEC at 05:06:07
        do_reset();
        set_time(5, 6, 7);
        check_state("preset_567", 3, 5, 6, 7);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        $display("rst_in_set: sel=%0d %0d:%0d:%0d", sel_field, hour, min, sec);
        check_state("rst_in_set", 0, 0, 0, 0);
        check_pulses("rst_in_set", 0, 0, 0);

        // mode_btn on terminal count: move to SET_HOUR and still count
        do_reset();
        repeat (TPS - 1) cycle();
        pulse(1'b1, 1'b0);
        $display("mode_at_tc: sel=%0d sec=%0d tick=%0b", sel_field, sec, sec_tick);
        check_state("mode_at_tc", 1, 0, 0, 1);
        check("mode_at_tc.sec_tick", int'(sec_tick), 1);
        repeat (2 * TPS) cycle();
        check_state("mode_at_tc_frozen", 1, 0, 0, 1);
        check("mode_at_tc_frozen.sec_tick", int'(sec_tick), 0);

        // Reset on terminal count wins
        do_reset();
        repeat (TPS - 1) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_state("rst_at_tc", 0, 0, 0, 0);
        check("rst_at_tc.sec_tick", int'(sec_tick), 0);

        // Alarm at 00:02:00, enabled
        alarm_hour = 6'd0;
        alarm_min  = 6'd2;
        alarm_on   = 1'b1;
        do_reset();
        hits      = 0;
        hit_cycle = -1;
        for (int i = 1; i <= 600; i++) begin
            cycle();
            if (alarm_hit) begin
                hits++;
                hit_cycle = i;
                check_state("alarm_hit_time", 0, 0, 2, 0);
            end
        end
        $display("alarm_on: hits=%0d at cycle %0d", hits, hit_cycle);
        check("alarm_on.hits", hits, ALARM_BUILT);
        check("alarm_on.cycle", hit_cycle, (ALARM_BUILT != 0) ? 120 * TPS : -1);

        // Alarm disabled
        alarm_on = 1'b0;
        do_reset();
        hits = 0;
        for (int i = 1; i <= 600; i++) begin
            cycle();
            hits += int'(alarm_hit);
        end
        $display("alarm_off: hits=%0d", hits);
        check("alarm_off.hits", hits, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
